// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared Hamming(7,4) definitions for the serial link (encoder, injector and
// decoder side): frame geometry, wire bit positions and decoder FSM states.
//
// Wire order, position 1 first: p1 p2 d1 p4 d2 d3 d4, followed by the overall
// parity bit p0 as position 8 when the SECDED_EN macro is defined.
// Position n is stored at bit n-1 of a codeword vector.
// -----------------------------------------------------------------------------
package hamming_pkg;

  localparam int CW_LEN   = 7;
  localparam int DATA_LEN = 4;

  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_D1 = 3;
  localparam int POS_P4 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;
  localparam int POS_D4 = 7;

`ifdef SECDED_EN
  localparam int FRAME_LEN = CW_LEN + 1;
`else
  localparam int FRAME_LEN = CW_LEN;
`endif

  typedef enum logic [1:0] {
    ST_RX    = 2'd0,
    ST_CHECK = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/hamming_syndrome.sv
// -----------------------------------------------------------------------------
// hamming_syndrome
// Combinational Hamming(7,4) syndrome and single-error corrector. Shared with
// the parallel decoder.
//
// Ports
//   i_cw        in  7  received codeword, position n at bit n-1
//   o_syndrome  out 3  XOR of the indices of all set positions (0 = clean)
//   o_data      out 4  corrected data, o_data[0]=d1 .. o_data[3]=d4
// -----------------------------------------------------------------------------
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CW_LEN-1:0]   i_cw,
  output logic [2:0]          o_syndrome,
  output logic [DATA_LEN-1:0] o_data
);

  logic [2:0]        w_syn;
  logic [CW_LEN-1:0] w_flip;
  logic [CW_LEN-1:0] w_fix;

  // Each syndrome bit checks the positions whose index has that bit set.
  assign w_syn[0] = i_cw[POS_P1-1] ^ i_cw[POS_D1-1] ^ i_cw[POS_D2-1] ^ i_cw[POS_D4-1];
  assign w_syn[1] = i_cw[POS_P2-1] ^ i_cw[POS_D1-1] ^ i_cw[POS_D3-1] ^ i_cw[POS_D4-1];
  assign w_syn[2] = i_cw[POS_P4-1] ^ i_cw[POS_D2-1] ^ i_cw[POS_D3-1] ^ i_cw[POS_D4-1];

  // A non-zero syndrome is the 1-based position of the flipped bit.
  always_comb begin
    w_flip = '0;
    if (w_syn != 3'd0) w_flip[w_syn - 3'd1] = 1'b1;
    w_fix = i_cw ^ w_flip;
  end

  assign o_syndrome = w_syn;
  assign o_data     = {w_fix[POS_D4-1], w_fix[POS_D3-1], w_fix[POS_D2-1], w_fix[POS_D1-1]};

endmodule

// File: rtl/hamming_dec_s.sv
// -----------------------------------------------------------------------------
// hamming_dec_s
// Serial Hamming(7,4) receiver/corrector. Collects one codeword bit per
// strobe_in, checks/corrects it in one cycle, then replays d1..d4 serially on
// d_out with a strobe_out pulse per bit, spaced 1+OUT_GAP clocks apart.
//
// Build option: define SECDED_EN to receive an 8th bit (overall parity p0)
// and flag uncorrectable double errors on dbl_err.
//
// Parameters
//   OUT_GAP     idle clocks between successive strobe_out pulses (0..15)
// Ports
//   clk         in  1  clock, rising edge
//   rst_n       in  1  asynchronous active-low reset
//   d_in        in  1  serial codeword bit, sampled when strobe_in=1
//   strobe_in   in  1  bit-valid qualifier
//   ready       out 1  1 while accepting bits
//   d_out       out 1  corrected data bit, valid with strobe_out
//   strobe_out  out 1  one-cycle pulse per data bit
//   frame_done  out 1  pulses together with the last strobe_out
//   syndrome    out 3  syndrome of the last frame (held)
//   err_corr    out 1  last frame had a corrected single error (held)
//   dbl_err     out 1  last frame had a double error (held, 0 w/o SECDED_EN)
//   overrun     out 1  pulses when a bit arrived while not ready (bit dropped)
// -----------------------------------------------------------------------------
module hamming_dec_s
  import hamming_pkg::*;
#(
  parameter int OUT_GAP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_in,
  input  logic       strobe_in,
  output logic       ready,
  output logic       d_out,
  output logic       strobe_out,
  output logic       frame_done,
  output logic [2:0] syndrome,
  output logic       err_corr,
  output logic       dbl_err,
  output logic       overrun
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_LEN - 1);
  localparam logic [3:0] GAP_RLD  = 4'(OUT_GAP);

  state_t                r_state;
  logic [FRAME_LEN-1:0]  r_cw;
  logic [2:0]            r_cnt;
  logic [2:0]            r_idx;
  logic [3:0]            r_gap;
  logic [DATA_LEN-1:0]   r_data;
  logic                  r_ready;
  logic                  r_d_out;
  logic                  r_strobe_out;
  logic                  r_frame_done;
  logic [2:0]            r_syn;
  logic                  r_err_corr;
  logic                  r_dbl;
  logic                  r_overrun;

  logic [2:0]            w_syn;
  logic [DATA_LEN-1:0]   w_data_fix;
  logic [DATA_LEN-1:0]   w_data_sel;
  logic                  w_err;
  logic                  w_dbl;

  hamming_syndrome u_syn (
    .i_cw       (r_cw[CW_LEN-1:0]),
    .o_syndrome (w_syn),
    .o_data     (w_data_fix)
  );

`ifdef SECDED_EN
  logic                w_par;
  logic [DATA_LEN-1:0] w_data_raw;

  assign w_par      = ^r_cw;
  assign w_data_raw = {r_cw[POS_D4-1], r_cw[POS_D3-1], r_cw[POS_D2-1], r_cw[POS_D1-1]};

  // Odd overall parity means exactly one flip (possibly p0 itself, where the
  // syndrome is 0 and the data passes through unchanged). Even parity with a
  // non-zero syndrome is a double error: leave the data alone.
  always_comb begin
    w_data_sel = w_data_fix;
    w_err      = 1'b0;
    w_dbl      = 1'b0;
    if (w_par) begin
      w_err = 1'b1;
    end else if (w_syn != 3'd0) begin
      w_dbl      = 1'b1;
      w_data_sel = w_data_raw;
    end
  end
`else
  assign w_data_sel = w_data_fix;
  assign w_err      = (w_syn != 3'd0);
  assign w_dbl      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RX;
      r_cw         <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_gap        <= '0;
      r_data       <= '0;
      r_ready      <= 1'b1;
      r_d_out      <= 1'b0;
      r_strobe_out <= 1'b0;
      r_frame_done <= 1'b0;
      r_syn        <= '0;
      r_err_corr   <= 1'b0;
      r_dbl        <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_strobe_out <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= strobe_in && (r_state != ST_RX);

      case (r_state)
        ST_RX: begin
          if (strobe_in) begin
            r_cw[r_cnt] <= d_in;
            r_cnt       <= r_cnt + 3'd1;
            if (r_cnt == LAST_BIT) begin
              r_state <= ST_CHECK;
              r_ready <= 1'b0;
            end
          end
        end

        ST_CHECK: begin
          r_syn      <= w_syn;
          r_err_corr <= w_err;
          r_dbl      <= w_dbl;
          r_data     <= w_data_sel;
          r_cnt      <= '0;
          r_idx      <= '0;
          r_gap      <= '0;
          r_state    <= ST_EMIT;
        end

        ST_EMIT: begin
          // r_idx==4 is the idle cycle after d4 has been emitted.
          if (r_idx == 3'd4) begin
            r_state <= ST_RX;
            r_ready <= 1'b1;
          end else if (r_gap == 4'd0) begin
            r_strobe_out <= 1'b1;
            r_d_out      <= r_data[r_idx[1:0]];
            r_frame_done <= (r_idx == 3'd3);
            r_idx        <= r_idx + 3'd1;
            r_gap        <= GAP_RLD;
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end

        default: begin
          r_state <= ST_RX;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready      = r_ready;
  assign d_out      = r_d_out;
  assign strobe_out = r_strobe_out;
  assign frame_done = r_frame_done;
  assign syndrome   = r_syn;
  assign err_corr   = r_err_corr;
  assign dbl_err    = r_dbl;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_hamming_dec_s.sv
// -----------------------------------------------------------------------------
// tb_hamming_dec_s
// Bench for hamming_dec_s. Two instances share the serial input: u_dut0 with
// OUT_GAP=0 and u_dut1 with OUT_GAP=2. Define SECDED_EN to cover the 8-bit
// frame variant.
// -----------------------------------------------------------------------------
module tb_hamming_dec_s;

`ifdef SECDED_EN
  localparam int FLEN = 8;
`else
  localparam int FLEN = 7;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_in;
  logic       strobe_in;
  logic [1:0] rdy, dout, so, fd, ec, de, ov;
  logic [2:0] syn [2];

  int n_checks = 0;
  int n_pass   = 0;

  hamming_dec_s #(.OUT_GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .strobe_in(strobe_in),
    .ready(rdy[0]), .d_out(dout[0]), .strobe_out(so[0]), .frame_done(fd[0]),
    .syndrome(syn[0]), .err_corr(ec[0]), .dbl_err(de[0]), .overrun(ov[0])
  );

  hamming_dec_s #(.OUT_GAP(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .strobe_in(strobe_in),
    .ready(rdy[1]), .d_out(dout[1]), .strobe_out(so[1]), .frame_done(fd[1]),
    .syndrome(syn[1]), .err_corr(ec[1]), .dbl_err(de[1]), .overrun(ov[1])
  );

  always #5 clk = ~clk;

  // Reference encoder: data d[0]=d1..d[3]=d4 placed at positions 3,5,6,7;
  // parity at position 2^k covers every data position whose index has bit k.
  // Bit 7 of the result is the overall parity p0.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] cw;
    int dpos [4];
    dpos = '{3, 5, 6, 7};
    cw = '0;
    for (int i = 0; i < 4; i++) cw[dpos[i]-1] = d[i];
    for (int p = 1; p <= 7; p++)
      for (int k = 0; k < 3; k++)
        if (((p & (1 << k)) != 0) && (p != (1 << k)) && cw[p-1])
          cw[(1 << k) - 1] = ~cw[(1 << k) - 1];
    cw[7] = ^cw[6:0];
    return cw;
  endfunction

  // Expected decoder results for a received frame rx carrying original data.
  task automatic model(input logic [7:0] rx, input logic [3:0] orig,
                       output logic [2:0] s, output logic e_c, output logic e_d,
                       output logic [3:0] d);
    int acc;
    acc = 0;
    for (int p = 1; p <= 7; p++) if (rx[p-1]) acc = acc ^ p;
    s = 3'(acc);
`ifdef SECDED_EN
    if (^rx) begin
      e_c = 1'b1; e_d = 1'b0; d = orig;
    end else if (acc != 0) begin
      e_c = 1'b0; e_d = 1'b1; d = {rx[6], rx[5], rx[4], rx[2]};
    end else begin
      e_c = 1'b0; e_d = 1'b0; d = orig;
    end
`else
    e_c = (acc != 0); e_d = 1'b0; d = orig;
`endif
  endtask

  task automatic send_frame(input logic [7:0] rx, input int nbits, input bit rand_gaps);
    for (int i = 0; i < nbits; i++) begin
      if (rand_gaps) begin
        int g;
        g = $urandom_range(0, 2);
        strobe_in = 1'b0;
        repeat (g) @(negedge clk);
      end
      strobe_in = 1'b1;
      d_in      = rx[i];
      @(negedge clk);
    end
    strobe_in = 1'b0;
    d_in      = 1'b0;
  endtask

  // Follows one instance through its emit phase right after send_frame.
  task automatic collect(input int sel, input logic [3:0] ed, input logic [2:0] es,
                         input logic eec, input logic ede, input bit inject,
                         input string tag);
    int pulses, cyc, last, gap;
    bit ovp;
    logic [3:0] got;
    pulses = 0; cyc = 0; last = 0; ovp = 0; got = '0;
    gap = (sel == 1) ? 2 : 0;
    while (pulses < 4 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (ovp) begin
        ovp = 0;
        strobe_in = 1'b0;
        n_checks++;
        if (ov[sel] !== 1'b1) $display("FAIL %s overrun got %b exp 1", tag, ov[sel]);
        else n_pass++;
      end
      if (so[sel] === 1'b1) begin
        got[pulses] = dout[sel];
        n_checks++;
        if (pulses == 0) begin
          if (cyc != 2) $display("FAIL %s latency got %0d exp 2", tag, cyc);
          else n_pass++;
        end else begin
          if (cyc - last != 1 + gap) $display("FAIL %s spacing got %0d exp %0d", tag, cyc - last, 1 + gap);
          else n_pass++;
        end
        last = cyc;
        n_checks++;
        if (fd[sel] !== (pulses == 3)) $display("FAIL %s frame_done pulse%0d got %b exp %b", tag, pulses, fd[sel], pulses == 3);
        else n_pass++;
        if (inject && pulses == 0) begin
          strobe_in = 1'b1;
          d_in      = 1'b1;
          ovp       = 1;
        end
        pulses++;
      end
    end
    n_checks++;
    if (pulses != 4) $display("FAIL %s strobe_out count got %0d exp 4", tag, pulses);
    else n_pass++;
    n_checks++;
    if (got !== ed) $display("FAIL %s data got %b exp %b", tag, got, ed);
    else n_pass++;
    n_checks++;
    if (syn[sel] !== es) $display("FAIL %s syndrome got %0d exp %0d", tag, syn[sel], es);
    else n_pass++;
    n_checks++;
    if (ec[sel] !== eec) $display("FAIL %s err_corr got %b exp %b", tag, ec[sel], eec);
    else n_pass++;
    n_checks++;
    if (de[sel] !== ede) $display("FAIL %s dbl_err got %b exp %b", tag, de[sel], ede);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rdy[sel] !== 1'b1) $display("FAIL %s ready after frame got %b exp 1", tag, rdy[sel]);
    else n_pass++;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (rdy !== 2'b11 && c < 100) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (rdy !== 2'b11) $display("FAIL %s idle timeout ready got %b exp 11", tag, rdy);
    else n_pass++;
  endtask

  task automatic run_frame(input int sel, input logic [7:0] rx, input logic [3:0] orig,
                           input bit rand_gaps, input bit inject, input string tag);
    logic [2:0] s;
    logic       e_c, e_d;
    logic [3:0] d;
    model(rx, orig, s, e_c, e_d, d);
    send_frame(rx, FLEN, rand_gaps);
    collect(sel, d, s, e_c, e_d, inject, tag);
    wait_idle(tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; strobe_in = 1'b0; d_in = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rdy[0], so[0], fd[0], dout[0], ec[0], de[0], ov[0]} !== 7'b1000000)
      $display("FAIL reset outputs got %b exp 1000000", {rdy[0], so[0], fd[0], dout[0], ec[0], de[0], ov[0]});
    else n_pass++;
    n_checks++;
    if (syn[0] !== 3'd0) $display("FAIL reset syndrome got %0d exp 0", syn[0]);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean();
    logic [7:0] cw;
    cw = encode(4'b1101);  // d1=1 d2=0 d3=1 d4=1
    n_checks++;
    if (cw[6:0] !== 7'b1100110) $display("FAIL encode example got %b exp 1100110", cw[6:0]);
    else n_pass++;
    run_frame(0, cw, 4'b1101, 0, 0, "clean");
  endtask

  task automatic test_single_err();
    logic [7:0] cw;
    cw = encode(4'b1101);
    run_frame(0, cw ^ 8'h10, 4'b1101, 0, 0, "flip_pos5");
    run_frame(0, cw ^ 8'h01, 4'b1101, 0, 0, "flip_pos1");
  endtask

  task automatic test_overrun();
    logic [7:0] cw;
    cw = encode(4'b1101);
    run_frame(0, cw, 4'b1101, 0, 1, "overrun");
    run_frame(0, cw, 4'b1101, 0, 0, "after_overrun");
  endtask

  task automatic test_reset_mid();
    logic [7:0] cw;
    cw = encode(4'b1101);
    send_frame(8'b0000_0111, 3, 0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rdy !== 2'b11) $display("FAIL mid_reset ready got %b exp 11", rdy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, cw, 4'b1101, 0, 0, "after_reset");
  endtask

  task automatic test_secded();
`ifdef SECDED_EN
    logic [7:0] cw;
    cw = encode(4'b1101);
    run_frame(0, cw ^ 8'h22, 4'b1101, 0, 0, "double_2_6");
    run_frame(0, cw ^ 8'h80, 4'b1101, 0, 0, "flip_p0");
`endif
  endtask

  task automatic test_out_gap();
    logic [7:0] cw;
    cw = encode(4'b0110);
    run_frame(1, cw ^ 8'h04, 4'b0110, 0, 0, "gap2");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [3:0] d;
      logic [7:0] rx;
      int kind, a, b;
      d  = 4'($urandom_range(0, 15));
      rx = encode(d);
      kind = $urandom_range(0, 2);
      a = $urandom_range(1, FLEN);
      b = (a % FLEN) + 1;
      if (kind >= 1) rx[a-1] = ~rx[a-1];
`ifdef SECDED_EN
      if (kind == 2) rx[b-1] = ~rx[b-1];
`endif
      run_frame(n % 2, rx, d, 1, 0, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_err();
    test_overrun();
    test_reset_mid();
    test_secded();
    test_out_gap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
